// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared state, grant and owner encodings for the SDRAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
package sdram_arb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_F    = 3'd1;
    localparam logic [2:0] ST_RD_M    = 3'd2;
    localparam logic [2:0] ST_WR_M    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_F_RD = 2'd1;
    localparam logic [1:0] GNT_M_RD = 2'd2;
    localparam logic [1:0] GNT_M_WR = 2'd3;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_M = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sdram_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rr_pick
// Brief    : Two-way round-robin picker; one-hot pick, bit0 fetch, bit1 mem.
// Revision : 1.0  initial release
// ============================================================================
module sdram_rr_pick
    import sdram_arb_pkg::*;
(
    input  logic       i_req_f,
    input  logic       i_req_m,
    input  logic       i_last_owner,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = 2'b00;
        if (i_req_f && i_req_m) begin
            // On contention the side that did not win last time goes next.
            o_pick = (i_last_owner == OWN_M) ? 2'b01 : 2'b10;
        end else if (i_req_f) begin
            o_pick = 2'b01;
        end else if (i_req_m) begin
            o_pick = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Grant FSM sharing one SDRAM port between fetch and mem stage.
// Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_rd_req,
    input  logic [AW-1:0] f_rd_addr,
    output logic          f_rd_fin,
    output logic [DW-1:0] f_rd_data,
    input  logic          m_rd_req,
    input  logic [AW-1:0] m_rd_addr,
    output logic          m_rd_fin,
    output logic [DW-1:0] m_rd_data,
    input  logic          m_wr_req,
    input  logic [AW-1:0] m_wr_addr,
    input  logic [DW-1:0] m_wr_data,
    output logic          m_wr_fin,
    output logic          sdram_rd_req,
    output logic [AW-1:0] sdram_rd_addr,
    input  logic          sdram_rd_fin,
    input  logic [DW-1:0] sdram_rd_data,
    output logic          sdram_wr_req,
    output logic [AW-1:0] sdram_wr_addr,
    output logic [DW-1:0] sdram_wr_data,
    input  logic          sdram_wr_fin,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout_err
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(TIMEOUT_CYCLES);

    logic [2:0]         r_state;
    logic               r_last_owner;
    logic [1:0]         r_grant;
    logic               r_busy;
    logic               r_timeout_err;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_f_rd_fin;
    logic               r_m_rd_fin;
    logic               r_m_wr_fin;
    logic [DW-1:0]      r_f_rd_data;
    logic [DW-1:0]      r_m_rd_data;
    logic               r_sdram_rd_req;
    logic [AW-1:0]      r_sdram_rd_addr;
    logic               r_sdram_wr_req;
    logic [AW-1:0]      r_sdram_wr_addr;
    logic [DW-1:0]      r_sdram_wr_data;

    logic [1:0]         w_pick;
    logic               w_wait_inc;
    logic [c_cnt_w-1:0] w_cnt_next;

    sdram_rr_pick u_pick (
        .i_req_f      (f_rd_req),
        .i_req_m      (m_rd_req | m_wr_req),
        .i_last_owner (r_last_owner),
        .o_pick       (w_pick)
    );

    // Saturating wait counter; a zero limit keeps the watchdog inert.
    assign w_wait_inc = (TIMEOUT_CYCLES != 0) && (r_wait_cnt != c_wait_limit);
    assign w_cnt_next = r_wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_last_owner    <= OWN_M;
            r_grant         <= GNT_NONE;
            r_busy          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_wait_cnt      <= '0;
            r_f_rd_fin      <= 1'b0;
            r_m_rd_fin      <= 1'b0;
            r_m_wr_fin      <= 1'b0;
            r_f_rd_data     <= '0;
            r_m_rd_data     <= '0;
            r_sdram_rd_req  <= 1'b0;
            r_sdram_rd_addr <= '0;
            r_sdram_wr_req  <= 1'b0;
            r_sdram_wr_addr <= '0;
            r_sdram_wr_data <= '0;
        end else begin
            r_f_rd_fin <= 1'b0;
            r_m_rd_fin <= 1'b0;
            r_m_wr_fin <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_pick[0]) begin
                        r_state         <= ST_RD_F;
                        r_grant         <= GNT_F_RD;
                        r_busy          <= 1'b1;
                        r_last_owner    <= OWN_F;
                        r_sdram_rd_req  <= 1'b1;
                        r_sdram_rd_addr <= f_rd_addr;
                    end else if (w_pick[1]) begin
                        r_busy       <= 1'b1;
                        r_last_owner <= OWN_M;
                        // A simultaneous mem read and write serves the write.
                        if (m_wr_req) begin
                            r_state         <= ST_WR_M;
                            r_grant         <= GNT_M_WR;
                            r_sdram_wr_req  <= 1'b1;
                            r_sdram_wr_addr <= m_wr_addr;
                            r_sdram_wr_data <= m_wr_data;
                        end else begin
                            r_state         <= ST_RD_M;
                            r_grant         <= GNT_M_RD;
                            r_sdram_rd_req  <= 1'b1;
                            r_sdram_rd_addr <= m_rd_addr;
                        end
                    end
                end
                ST_RD_F, ST_RD_M: begin
                    if (sdram_rd_fin) begin
                        r_sdram_rd_req <= 1'b0;
                        r_grant        <= GNT_NONE;
                        r_state        <= ST_RELEASE;
                        if (r_state == ST_RD_F) begin
                            r_f_rd_fin  <= 1'b1;
                            r_f_rd_data <= sdram_rd_data;
                        end else begin
                            r_m_rd_fin  <= 1'b1;
                            r_m_rd_data <= sdram_rd_data;
                        end
                    end else if (w_wait_inc) begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_cnt_next == c_wait_limit) r_timeout_err <= 1'b1;
                    end
                end
                ST_WR_M: begin
                    if (sdram_wr_fin) begin
                        r_sdram_wr_req <= 1'b0;
                        r_grant        <= GNT_NONE;
                        r_state        <= ST_RELEASE;
                        r_m_wr_fin     <= 1'b1;
                    end else if (w_wait_inc) begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_cnt_next == c_wait_limit) r_timeout_err <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_grant        <= GNT_NONE;
                    r_busy         <= 1'b0;
                    r_sdram_rd_req <= 1'b0;
                    r_sdram_wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign f_rd_fin      = r_f_rd_fin;
    assign f_rd_data     = r_f_rd_data;
    assign m_rd_fin      = r_m_rd_fin;
    assign m_rd_data     = r_m_rd_data;
    assign m_wr_fin      = r_m_wr_fin;
    assign sdram_rd_req  = r_sdram_rd_req;
    assign sdram_rd_addr = r_sdram_rd_addr;
    assign sdram_wr_req  = r_sdram_wr_req;
    assign sdram_wr_addr = r_sdram_wr_addr;
    assign sdram_wr_data = r_sdram_wr_data;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Directed scoreboard bench for sdram_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam logic [31:0] c_mask = 32'hDEADBFEF;
    localparam logic [31:0] c_kf   = 32'd1;
    localparam logic [31:0] c_kmr  = 32'd2;
    localparam logic [31:0] c_kmw  = 32'd3;

    typedef struct packed {
        logic [31:0] kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_rd_req = 1'b0;
    logic [31:0] f_rd_addr = '0;
    logic        f_rd_fin;
    logic [31:0] f_rd_data;
    logic        m_rd_req = 1'b0;
    logic [31:0] m_rd_addr = '0;
    logic        m_rd_fin;
    logic [31:0] m_rd_data;
    logic        m_wr_req = 1'b0;
    logic [31:0] m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    logic        m_wr_fin;
    logic        sdram_rd_req;
    logic [31:0] sdram_rd_addr;
    logic        sdram_rd_fin = 1'b0;
    logic [31:0] sdram_rd_data = '0;
    logic        sdram_wr_req;
    logic [31:0] sdram_wr_addr;
    logic [31:0] sdram_wr_data;
    logic        sdram_wr_fin = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    bit   sd_auto = 1'b0;
    int   sd_lat  = 1;

    sdram_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .f_rd_req(f_rd_req), .f_rd_addr(f_rd_addr), .f_rd_fin(f_rd_fin), .f_rd_data(f_rd_data),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_fin(m_rd_fin), .m_rd_data(m_rd_data),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_fin(m_wr_fin),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
        .sdram_rd_fin(sdram_rd_fin), .sdram_rd_data(sdram_rd_data),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_data(sdram_wr_data), .sdram_wr_fin(sdram_wr_fin),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] kind, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_fin: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            chk("fin_order", kind, e.kind);
            if (kind != c_kmw) chk("rd_data", data, e.data);
        end
    endtask

    // Scoreboard monitor: every requester fin pops one expected completion.
    always @(negedge clk) begin
        if (reset) begin
            if (f_rd_fin) pop_chk(c_kf, f_rd_data);
            if (m_rd_fin) pop_chk(c_kmr, m_rd_data);
            if (m_wr_fin) pop_chk(c_kmw, 32'd0);
        end
    end

    // SDRAM responder: fin sd_lat cycles after req first seen; data derived from address.
    initial begin
        int cnt = 0;
        bit done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sd_auto) begin
                sdram_rd_fin = 1'b0;
                sdram_wr_fin = 1'b0;
                if ((sdram_rd_req || sdram_wr_req) && !done) begin
                    if (cnt == sd_lat) begin
                        if (sdram_rd_req) begin
                            sdram_rd_fin  = 1'b1;
                            sdram_rd_data = sdram_rd_addr ^ c_mask;
                        end else begin
                            sdram_wr_fin = 1'b1;
                        end
                        done = 1'b1;
                    end else begin
                        cnt++;
                    end
                end else if (!sdram_rd_req && !sdram_wr_req) begin
                    cnt  = 0;
                    done = 1'b0;
                end
            end else begin
                cnt  = 0;
                done = 1'b0;
            end
        end
    end

    // Waits for fins, dropping each mem request as its own fin pulses.
    task automatic serve_mem(input bit want_wr, input bit want_rd, input string nm);
        bit wr_done = !want_wr;
        bit rd_done = !want_rd;
        for (int k = 0; k < 80 && !(wr_done && rd_done); k++) begin
            next();
            if (m_wr_fin) begin m_wr_req = 1'b0; wr_done = 1'b1; end
            if (m_rd_fin) begin m_rd_req = 1'b0; rd_done = 1'b1; end
        end
        if (!(wr_done && rd_done)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no fin expected fin within 80 cycles", nm);
        end
    endtask

    task automatic wait_f(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            next();
            got = f_rd_fin;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no fin expected fin within 80 cycles", nm);
        end
        f_rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) next();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sd_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        chk("rst_f_rd_data", f_rd_data, 32'd0);
        reset = 1'b1;
        next();

        // Both read sides held continuously: fetch, mem, fetch, mem
        sd_auto = 1'b1;
        sd_lat  = 1;
        push(c_kf, 32'h300 ^ c_mask);
        push(c_kmr, 32'h400 ^ c_mask);
        push(c_kf, 32'h300 ^ c_mask);
        push(c_kmr, 32'h400 ^ c_mask);
        f_rd_req = 1'b1; f_rd_addr = 32'h300;
        m_rd_req = 1'b1; m_rd_addr = 32'h400;
        next();
        chk("alt_first_grant", {30'd0, grant}, 32'd1);
        begin
            int seen = 0;
            for (int k = 0; k < 80 && seen < 4; k++) begin
                next();
                if (f_rd_fin || m_rd_fin) seen++;
            end
            chk("alt_fin_count", seen, 32'd4);
        end
        f_rd_req = 1'b0;
        m_rd_req = 1'b0;
        repeat (3) next();

        // Fetch-only read with a 3-cycle SDRAM
        sd_lat = 3;
        f_rd_req = 1'b1; f_rd_addr = 32'h100;
        push(c_kf, 32'hDEADBEEF);
        next();
        chk("f1_sd_rd_req", {31'd0, sdram_rd_req}, 32'd1);
        chk("f1_sd_rd_addr", sdram_rd_addr, 32'h100);
        chk("f1_grant_c1", {30'd0, grant}, 32'd1);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        for (int c = 2; c <= 4; c++) begin
            next();
            chk("f1_grant_hold", {30'd0, grant}, 32'd1);
            chk("f1_fin_early", {31'd0, f_rd_fin}, 32'd0);
        end
        next();
        chk("f1_fin_c5", {31'd0, f_rd_fin}, 32'd1);
        chk("f1_grant_c5", {30'd0, grant}, 32'd0);
        f_rd_req = 1'b0;
        next();
        chk("f1_fin_once", {31'd0, f_rd_fin}, 32'd0);
        chk("f1_idle_busy", {31'd0, busy}, 32'd0);
        repeat (2) next();

        // Write with a stray read fin in the middle
        sd_auto = 1'b0;
        m_wr_req = 1'b1; m_wr_addr = 32'h200; m_wr_data = 32'h12345678;
        push(c_kmw, 32'd0);
        next();
        chk("w_sd_wr_req", {31'd0, sdram_wr_req}, 32'd1);
        chk("w_sd_wr_addr", sdram_wr_addr, 32'h200);
        chk("w_sd_wr_data", sdram_wr_data, 32'h12345678);
        chk("w_grant_c1", {30'd0, grant}, 32'd3);
        chk("w_sd_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        next();
        sdram_rd_data = 32'hBAD0BAD0;
        sdram_rd_fin  = 1'b1;
        next();
        sdram_rd_fin = 1'b0;
        chk("w_grant_c3", {30'd0, grant}, 32'd3);
        chk("w_still_req", {31'd0, sdram_wr_req}, 32'd1);
        next();
        sdram_wr_fin = 1'b1;
        chk("w_grant_c4", {30'd0, grant}, 32'd3);
        next();
        sdram_wr_fin = 1'b0;
        chk("w_fin_c5", {31'd0, m_wr_fin}, 32'd1);
        m_wr_req = 1'b0;
        next();
        chk("w_fin_once", {31'd0, m_wr_fin}, 32'd0);
        chk("w_f_data_kept", f_rd_data, 32'hDEADBEEF);
        repeat (2) next();

        // Mem read and write together: write first, then read
        sd_auto = 1'b1;
        sd_lat  = 1;
        push(c_kmw, 32'd0);
        push(c_kmr, 32'h280 ^ c_mask);
        m_wr_req = 1'b1; m_wr_addr = 32'h240; m_wr_data = 32'hCAFEF00D;
        m_rd_req = 1'b1; m_rd_addr = 32'h280;
        next();
        chk("rw_grant", {30'd0, grant}, 32'd3);
        chk("rw_wr_data", sdram_wr_data, 32'hCAFEF00D);
        serve_mem(1'b1, 1'b1, "rw");
        repeat (3) next();

        // Reset two cycles into an RD_M wait
        sd_auto = 1'b0;
        m_rd_req = 1'b1; m_rd_addr = 32'h500;
        next();
        chk("r_grant_mrd", {30'd0, grant}, 32'd2);
        chk("r_sd_addr", sdram_rd_addr, 32'h500);
        next();
        f_rd_req = 1'b1; f_rd_addr = 32'h600;
        #1 reset = 1'b0;
        #1;
        chk("r_grant0", {30'd0, grant}, 32'd0);
        chk("r_busy0", {31'd0, busy}, 32'd0);
        chk("r_sd_rd_req0", {31'd0, sdram_rd_req}, 32'd0);
        chk("r_sd_rd_addr0", sdram_rd_addr, 32'd0);
        chk("r_sd_wr_addr0", sdram_wr_addr, 32'd0);
        chk("r_sd_wr_data0", sdram_wr_data, 32'd0);
        chk("r_m_rd_data0", m_rd_data, 32'd0);
        chk("r_f_rd_data0", f_rd_data, 32'd0);
        chk("r_m_rd_fin0", {31'd0, m_rd_fin}, 32'd0);
        repeat (2) next();
        reset = 1'b1;
        sd_auto = 1'b1;
        sd_lat  = 0;
        push(c_kf, 32'h600 ^ c_mask);
        push(c_kmr, 32'h500 ^ c_mask);
        next();
        chk("r_fetch_first", {30'd0, grant}, 32'd1);
        wait_f("r_f");
        serve_mem(1'b0, 1'b1, "r_m");
        repeat (3) next();

        // Watchdog with a silent SDRAM
        sd_auto = 1'b0;
        chk("t_err_before", {31'd0, timeout_err}, 32'd0);
        f_rd_req = 1'b1; f_rd_addr = 32'h700;
        push(c_kf, 32'h700 ^ c_mask);
        repeat (8) next();
        chk("t_err_c8", {31'd0, timeout_err}, 32'd0);
        next();
        chk("t_err_c9", {31'd0, timeout_err}, 32'd1);
        chk("t_busy_wait", {31'd0, busy}, 32'd1);
        repeat (4) next();
        sdram_rd_data = 32'h700 ^ c_mask;
        sdram_rd_fin  = 1'b1;
        next();
        sdram_rd_fin = 1'b0;
        chk("t_late_fin", {31'd0, f_rd_fin}, 32'd1);
        f_rd_req = 1'b0;
        repeat (2) next();
        chk("t_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("t_idle", {31'd0, busy}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SIMPLE_SDRAM port between instruction fetch (read-only) and the memory stage (read or write).
- Replaces the state-based combinational mux in the processor top with an explicit grant FSM, round-robin fairness, registered SDRAM-side outputs and a stall watchdog.
- Sits between the fetch/mem-stage request ports and the SDRAM model. All handshakes are level req held until a one-cycle fin pulse.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 1024, SDRAM wait cycles before timeout_err is set; 0 disables the watchdog

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- f_rd_req  in  1  fetch read request, held until f_rd_fin
- f_rd_addr  in  AW  fetch read address
- f_rd_fin  out  1  one-cycle completion pulse to fetch
- f_rd_data  out  DW  fetch read data; valid with f_rd_fin and held until the next fetch completion
- m_rd_req  in  1  mem-stage read request
- m_rd_addr  in  AW  mem-stage read address
- m_rd_fin  out  1  one-cycle completion pulse to mem stage
- m_rd_data  out  DW  mem-stage read data; held like f_rd_data
- m_wr_req  in  1  mem-stage write request
- m_wr_addr  in  AW  write address
- m_wr_data  in  DW  write data
- m_wr_fin  out  1  one-cycle write completion pulse
- sdram_rd_req  out  1  read request to SDRAM
- sdram_rd_addr  out  AW  read address to SDRAM
- sdram_rd_fin  in  1  SDRAM read done pulse
- sdram_rd_data  in  DW  SDRAM read data
- sdram_wr_req  out  1  write request to SDRAM
- sdram_wr_addr  out  AW  write address to SDRAM
- sdram_wr_data  out  DW  write data to SDRAM
- sdram_wr_fin  in  1  SDRAM write done pulse
- grant  out  2  current owner: 0 none, 1 fetch, 2 mem read, 3 mem write
- busy  out  1  high when the FSM is not in IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async): state IDLE; every output, including data/address registers, goes to 0; last_owner=MEM so fetch wins the first contest. Any transfer in flight is abandoned and no fin is issued.
- States: IDLE, RD_F, RD_M, WR_M, RELEASE.
- IDLE arbitration, using requests sampled this cycle:
  - Mem side: m_wr_req has priority over m_rd_req. Both high together is a protocol violation, and the write is served.
  - If fetch and mem both request, the side not equal to last_owner wins. Otherwise the sole requester wins.
  - On grant: latch address/data, set last_owner, go to RD_F, RD_M or WR_M.
  - sdram_*_req and the registered address/data are asserted from the next cycle.
- RD_F, RD_M, WR_M:
  - Hold sdram_rd_req or sdram_wr_req and the address/data stable.
  - Ignore the fin of the other direction (a rd_fin during WR_M has no effect).
  - On the matching sdram fin: drop sdram req the next cycle, pulse the requester fin for exactly one cycle, register sdram_rd_data into that requester's data output, then go to RELEASE.
- RELEASE: exactly one cycle, then IDLE. Because the grant decision uses the cycle after RELEASE, a requester that drops req on its fin pulse is never re-granted spuriously.
- Latency, request seen high in IDLE at cycle 0:
  - sdram req high at cycle 1.
  - sdram fin at cycle N.
  - Requester fin at N+1.
  - Earliest next grant decision at N+3.
  - Minimum turnaround with a 1-cycle SDRAM is 4 cycles.
- Watchdog:
  - The wait counter clears on entry to RD_F, RD_M or WR_M and increments each cycle while waiting.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets and stays set until reset. The transfer is not aborted.
  - The counter saturates and does not wrap.
- sdram fin pulses arriving in IDLE or RELEASE are ignored.
- A requester dropping req mid-transfer does not cancel the transfer; its fin still pulses.
- grant and busy are registered and reflect the current state.

Decomposition:
- Package sdram_arb_pkg: state encoding constants; grant codes GNT_NONE, GNT_F_RD, GNT_M_RD, GNT_M_WR; owner codes OWN_F, OWN_M.
- One sub-module, sdram_rr_pick: combinational 2-way round-robin picker (inputs: two requests and last_owner; outputs: one-hot pick).

Test Plan:
- Fetch-only read of 0x100, SDRAM fin 3 cycles after req, data 0xDEADBEEF -> sdram_rd_addr=0x100 from cycle 1; f_rd_fin one pulse at cycle 5 with f_rd_data=0xDEADBEEF; grant=1 during cycles 1–4.
- Fetch and mem read requested together, each continuously after its fin -> grants alternate: fetch, mem, fetch, mem. After reset, fetch is first.
- m_wr_req addr 0x200 data 0x12345678 while an unwanted sdram_rd_fin pulse arrives -> the read fin is ignored; completes only on sdram_wr_fin; m_wr_fin pulses once; grant=3 throughout.
- TIMEOUT_CYCLES=8, SDRAM never acks -> timeout_err rises after 8 wait cycles and stays high. A later fin still completes the transfer, and timeout_err remains 1.
- Reset asserted low two cycles into an RD_M wait -> all outputs 0 immediately, no m_rd_fin; after release, a pending f_rd_req is granted first.
- m_rd_req and m_wr_req asserted simultaneously -> the write is served, and the read is served after RELEASE if still requested.
